// File: rtl/matrix_vec_mul_fx.sv
// Fixed-point matrix-vector multiply engine: y = A * x.
// Operands live in one flat word store (A row-major, then x). A start pulse
// runs one MAC per cycle; each finished row is rounded (half toward +inf),
// saturated to WORD_SIZE bits and offered on a valid/ready output port.
//
// Handshake: out_valid rises when a row result is ready and stays high, with
// out_data/out_idx held stable, until a rising src_clk edge sees
// out_valid & out_ready; that edge is the transfer. out_ready is a don't-care
// whenever out_valid is low.
module matrix_vec_mul_fx #(
    parameter int WORD_SIZE = 16,
    parameter int N         = 8,
    parameter int ADDR_W    = 9
) (
    input  logic                    src_clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WORD_SIZE-1:0]    data_wr,
    input  logic                    start,
    input  logic [3:0]              qf,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE-1:0]    out_data,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    done,
    output logic                    ovf
);

    localparam int RW    = $clog2(N);
    localparam int DEPTH = N * N + N;
    localparam int MW    = $clog2(DEPTH);
    localparam int AW    = 2 * WORD_SIZE + RW;
    localparam int PW    = 2 * WORD_SIZE;

    // FSM state is kept in state_q so checkers can bind to it directly.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_ROUND = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0]   mem [DEPTH];
    logic [RW-1:0]          r_q, k_q;
    logic signed [AW-1:0]   acc_q;
    logic [3:0]             qf_q;
    logic [WORD_SIZE-1:0]   out_data_q;
    logic [RW-1:0]          out_idx_q;
    logic                   ovf_q;

    logic                   wr_ok;
    logic                   last_k, last_r;
    logic [MW-1:0]          a_idx, x_idx;
    logic signed [PW-1:0]   a_ext, x_ext, prod;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW:0]     rnd, t_w, s_w;
    logic [AW-WORD_SIZE+1:0] upper;
    logic                   fits;
    logic [WORD_SIZE-1:0]   sat_val;

    assign wr_ok  = we && (state_q == S_IDLE) && (32'(addr) < DEPTH);
    assign last_k = (k_q == RW'(N - 1));
    assign last_r = (r_q == RW'(N - 1));

    // Operand addresses for the current MAC term.
    assign a_idx = MW'(32'(r_q) * N + 32'(k_q));
    assign x_idx = MW'(N * N + 32'(k_q));

    // Full-width signed product, sign-extended into the accumulator.
    assign a_ext    = PW'($signed(mem[a_idx]));
    assign x_ext    = PW'($signed(mem[x_idx]));
    assign prod     = a_ext * x_ext;
    assign acc_next = acc_q + AW'(prod);

    // Round half toward +inf, arithmetic shift, then range check: the result
    // fits when every bit from the WORD_SIZE sign position up is identical.
    assign rnd     = (qf_q != 4'd0) ? ((AW + 1)'(1) << (qf_q - 4'd1)) : '0;
    assign t_w     = (AW + 1)'(acc_q) + rnd;
    assign s_w     = t_w >>> qf_q;
    assign upper   = s_w[AW:WORD_SIZE-1];
    assign fits    = (&upper) || !(|upper);
    assign sat_val = s_w[AW] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                             : {1'b0, {(WORD_SIZE-1){1'b1}}};

    // Operand store: no reset, contents survive across runs and resets.
    always_ff @(posedge src_clk) begin
        if (wr_ok) begin
            mem[addr[MW-1:0]] <= data_wr;
        end
    end

    // State register.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MAC;
            S_MAC:   if (last_k) state_d = S_ROUND;
            S_ROUND: state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = last_r ? S_DONE : S_MAC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: run setup, accumulation, rounding/saturation, row stepping.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            qf_q       <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        qf_q  <= (32'(qf) > WORD_SIZE - 1) ? 4'(WORD_SIZE - 1) : qf;
                        ovf_q <= 1'b0;
                        r_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_next;
                    k_q   <= last_k ? '0 : k_q + 1'b1;
                end
                S_ROUND: begin
                    out_data_q <= fits ? s_w[WORD_SIZE-1:0] : sat_val;
                    out_idx_q  <= r_q;
                    if (!fits) begin
                        ovf_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready && !last_r) begin
                        r_q   <= r_q + 1'b1;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_matrix_vec_mul_fx.sv
// Directed bench for matrix_vec_mul_fx (N=8, WORD_SIZE=16, ADDR_W=9).
module tb_matrix_vec_mul_fx;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] data_wr;
    logic        start;
    logic [3:0]  qf;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        done;
    logic        ovf;

    int tests;
    int fails;
    int edge_cnt;

    logic [15:0] x_vals [8];
    logic [15:0] exp_y  [8];

    matrix_vec_mul_fx #(.WORD_SIZE(16), .N(8), .ADDR_W(9)) dut (
        .src_clk   (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .data_wr   (data_wr),
        .start     (start),
        .qf        (qf),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done),
        .ovf       (ovf)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        we      = 1'b1;
        addr    = 9'(a);
        data_wr = d;
        tick();
        we      = 1'b0;
    endtask

    // mode 0: identity A (0x0100 diag) with x_vals; 1: all 0x7FFF; 2: all zero.
    task automatic load(input int mode);
        for (int i = 0; i < 64; i++) begin
            if (mode == 0)      wr(i, (i / 8 == i % 8) ? 16'h0100 : 16'h0000);
            else if (mode == 1) wr(i, 16'h7FFF);
            else                wr(i, 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            if (mode == 0)      wr(64 + i, x_vals[i]);
            else if (mode == 1) wr(64 + i, 16'h7FFF);
            else                wr(64 + i, 16'h0000);
        end
    endtask

    task automatic set_exp(input int mode);
        for (int i = 0; i < 8; i++) begin
            if (mode == 0)      exp_y[i] = x_vals[i];
            else if (mode == 1) exp_y[i] = 16'h7FFF;
            else                exp_y[i] = 16'h0000;
        end
    endtask

    // One full run against exp_y. stall_row >= 0 holds out_ready low for 5
    // cycles on that row; inject issues a busy write to addr 0 plus a start.
    task automatic run(input string tag, input logic [3:0] q, input logic exp_ovf,
                       input int stall_row, input bit inject);
        int t0;
        int g;
        qf        = q;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        qf    = 4'd0;
        t0    = edge_cnt;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_ovf_clear"}, 32'(ovf), 32'd0);
        if (inject) begin
            we      = 1'b1;
            addr    = 9'd0;
            data_wr = 16'h5555;
            start   = 1'b1;
            tick();
            we    = 1'b0;
            start = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            g = 0;
            while (!out_valid && g < 200) begin
                tick();
                g++;
            end
            check({tag, "_valid_wait"}, 32'(out_valid), 32'd1);
            if (r == 0) check({tag, "_first_latency"}, 32'(edge_cnt - t0), 32'd9);
            check({tag, $sformatf("_data%0d", r)}, 32'(out_data), 32'(exp_y[r]));
            check({tag, $sformatf("_idx%0d", r)}, 32'(out_idx), 32'(r));
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "_stall_data"}, 32'(out_data), 32'(exp_y[r]));
                    check({tag, "_stall_idx"}, 32'(out_idx), 32'(r));
                end
                out_ready = 1'b1;
            end
            tick();
            if (r < 7) check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_cycle"}, 32'(edge_cnt - t0), (stall_row >= 0) ? 32'd85 : 32'd80);
        tick();
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    // Directed sequence.
    initial begin
        tests     = 0;
        fails     = 0;
        edge_cnt  = 0;
        rst_n     = 1'b0;
        we        = 1'b0;
        addr      = '0;
        data_wr   = '0;
        start     = 1'b0;
        qf        = '0;
        out_ready = 1'b0;
        x_vals[0] = 16'h0100; x_vals[1] = 16'hFF00; x_vals[2] = 16'h0080; x_vals[3] = 16'h0000;
        x_vals[4] = 16'h7FFF; x_vals[5] = 16'h8000; x_vals[6] = 16'h0001; x_vals[7] = 16'h1234;

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Identity: y = x.
        load(0);
        set_exp(0);
        run("ident", 4'd8, 1'b0, -1, 1'b0);

        // Saturation: every row overflows positive.
        load(1);
        set_exp(1);
        run("sat", 4'd0, 1'b1, -1, 1'b0);

        // Reset during MAC of row 4 of a saturating run.
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (42) tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        check("mid_ovf_pre", 32'(ovf), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run("after_rst", 4'd0, 1'b1, -1, 1'b0);

        // Identity rerun: ovf sticky until the next start clears it.
        load(0);
        set_exp(0);
        check("ovf_sticky_idle", 32'(ovf), 32'd1);
        run("rerun", 4'd8, 1'b0, -1, 1'b0);

        // Backpressure on row 2.
        run("bp", 4'd8, 1'b0, 2, 1'b0);

        // Busy write + mid-run start are ignored; then out-of-range writes.
        run("inject", 4'd8, 1'b0, -1, 1'b1);
        wr(72, 16'h5555);
        wr(511, 16'h5555);
        run("oor", 4'd8, 1'b0, -1, 1'b0);

        // Rounding: -3 * 1 with qf=1 -> -1.5 -> -1; then 3 -> 1.5 -> 2.
        load(2);
        wr(0, 16'hFFFD);
        wr(64, 16'h0001);
        set_exp(2);
        exp_y[0] = 16'hFFFF;
        run("rnd_neg", 4'd1, 1'b0, -1, 1'b0);
        wr(0, 16'h0003);
        exp_y[0] = 16'h0002;
        run("rnd_pos", 4'd1, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
